// File: rtl/tuner_pkg.sv
// Shared constants and FSM state type for the tuner magnitude datapath.
//   PTS_W        : width of bin count and bin address
//   DATA_W       : width of signed re/im samples
//   MAG_W        : magnitude width, always 2*DATA_W
//   DONE_TIMEOUT : default cycles to wait for the consumer's done flag
package tuner_pkg;

  localparam int unsigned PTS_W        = 11;
  localparam int unsigned DATA_W       = 16;
  localparam int unsigned MAG_W        = 2 * DATA_W;
  localparam int unsigned DONE_TIMEOUT = 4095;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDrain,
    StWaitDone,
    StClose
  } state_e;

endpackage

// File: rtl/mag_sq_pipe.sv
// re^2 + im^2 datapath with a valid bit travelling alongside the data.
// Stage 1 is the spectrum RAM's own output register, so only its valid bit lives here.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   flush      : synchronous clear of all valids and the magnitude output
//   rd_issued  : a RAM read is being issued this cycle
//   re, im     : signed RAM read data (valid one cycle after rd_issued)
//   mag        : magnitude squared, zero whenever no valid bin is in stage 3
//   pre_valid  : a valid bin will be in stage 3 on the next cycle
//   empty      : nothing in flight in any stage
module mag_sq_pipe #(
  parameter int unsigned DATA_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     rd_issued,
  input  logic signed [DATA_W-1:0] re,
  input  logic signed [DATA_W-1:0] im,
  output logic [2*DATA_W-1:0]      mag,
  output logic                     pre_valid,
  output logic                     empty
);

  localparam int unsigned PW = 2 * DATA_W;

  logic          v1_q, v2_q, v3_q;
  logic [PW-1:0] sq_re_q, sq_im_q, mag_q;
  logic signed [PW-1:0] re_x, im_x;

  // Sign-extend before squaring so the product is computed at full width.
  assign re_x = {{DATA_W{re[DATA_W-1]}}, re};
  assign im_x = {{DATA_W{im[DATA_W-1]}}, im};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
      sq_re_q <= '0;
      sq_im_q <= '0;
      mag_q   <= '0;
    end else if (flush) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
      sq_re_q <= '0;
      sq_im_q <= '0;
      mag_q   <= '0;
    end else begin
      v1_q <= rd_issued;
      v2_q <= v1_q;
      v3_q <= v2_q;
      if (v1_q) begin
        sq_re_q <= re_x * re_x;
        sq_im_q <= im_x * im_x;
      end
      // Empty slots read as zero so a trailing value never wins the peak search.
      mag_q <= v2_q ? (sq_re_q + sq_im_q) : '0;
    end
  end

  assign mag       = mag_q;
  assign pre_valid = v2_q;
  assign empty     = !(v1_q || v2_q || v3_q);

endmodule

// File: rtl/fft_mag_streamer.sv
// Reads one frame of FFT bins from the spectrum RAM and streams re^2+im^2 to the
// peak search, qualified by a level mag_start held until the consumer reports done.
// Ports:
//   clk, reset     : clock, asynchronous active-high reset
//   go, pts        : frame request and bin count (sampled in idle only)
//   rd_en, rd_addr : spectrum RAM read port
//   rd_re, rd_im   : RAM read data, valid one cycle after rd_en
//   mag_start, mag : magnitude stream to the consumer
//   done_in        : consumer done flag
//   busy           : frame in progress
//   frame_done     : one-cycle pulse on frame close
//   err            : sticky protocol/timeout error, cleared by the next accepted go
module fft_mag_streamer #(
  parameter int unsigned PTS_W        = tuner_pkg::PTS_W,
  parameter int unsigned DATA_W       = tuner_pkg::DATA_W,
  parameter int unsigned MAG_W        = 2 * DATA_W,
  parameter int unsigned DONE_TIMEOUT = tuner_pkg::DONE_TIMEOUT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     go,
  input  logic [PTS_W-1:0]         pts,
  output logic                     rd_en,
  output logic [PTS_W-1:0]         rd_addr,
  input  logic signed [DATA_W-1:0] rd_re,
  input  logic signed [DATA_W-1:0] rd_im,
  output logic                     mag_start,
  output logic [MAG_W-1:0]         mag,
  input  logic                     done_in,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     err
);

  import tuner_pkg::*;

  localparam int unsigned CNT_W = $clog2(DONE_TIMEOUT + 1);
  localparam logic [PTS_W-1:0] PtsOne = PTS_W'(1);
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DONE_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [PTS_W-1:0] pts_q, pts_d;
  logic [PTS_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rd_en_q, rd_en_d;
  logic             mag_start_q, mag_start_d;
  logic             err_q, err_d;
  logic             flush;
  logic             pre_valid, pipe_empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      pts_q       <= '0;
      addr_q      <= '0;
      cnt_q       <= '0;
      rd_en_q     <= 1'b0;
      mag_start_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pts_q       <= pts_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      rd_en_q     <= rd_en_d;
      mag_start_q <= mag_start_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pts_d       = pts_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    rd_en_d     = 1'b0;
    mag_start_d = mag_start_q;
    err_d       = err_q;
    flush       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (go) begin
          pts_d  = pts;
          err_d  = 1'b0;
          addr_d = '0;
          cnt_d  = '0;
          if (pts != '0) begin
            state_d = StFetch;
            rd_en_d = 1'b1;
          end else begin
            // Empty frame: present an all-zero stream straight away.
            state_d     = StWaitDone;
            mag_start_d = 1'b1;
          end
        end
      end
      StFetch: begin
        if (pre_valid) mag_start_d = 1'b1;
        if (done_in) begin
          err_d   = 1'b1;
          state_d = StClose;
        end else if (addr_q == pts_q - PtsOne) begin
          state_d = StDrain;
        end else begin
          addr_d  = addr_q + PtsOne;
          rd_en_d = 1'b1;
        end
      end
      StDrain: begin
        if (pre_valid) mag_start_d = 1'b1;
        if (done_in) begin
          err_d   = 1'b1;
          state_d = StClose;
        end else if (pipe_empty) begin
          state_d = StWaitDone;
          cnt_d   = '0;
        end
      end
      StWaitDone: begin
        if (done_in) begin
          state_d = StClose;
        end else if (cnt_q == CntLast) begin
          err_d   = 1'b1;
          state_d = StClose;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StClose: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Entering close drops the qualifier and empties the pipe (matters on error exits).
    if (state_d == StClose) begin
      mag_start_d = 1'b0;
      flush       = 1'b1;
    end
  end

  mag_sq_pipe #(
    .DATA_W(DATA_W)
  ) u_pipe (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .rd_issued(rd_en_q),
    .re       (rd_re),
    .im       (rd_im),
    .mag      (mag),
    .pre_valid(pre_valid),
    .empty    (pipe_empty)
  );

  assign rd_en      = rd_en_q;
  assign rd_addr    = addr_q;
  assign mag_start  = mag_start_q;
  assign busy       = (state_q != StIdle);
  assign frame_done = (state_q == StClose);
  assign err        = err_q;

endmodule

// File: tb/tb_fft_mag_streamer.sv
module tb_fft_mag_streamer;

  localparam int unsigned PTS_W  = 11;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned MAG_W  = 32;
  localparam int unsigned TO     = 16;

  logic                     clk = 1'b0;
  logic                     reset = 1'b1;
  logic                     go = 1'b0;
  logic                     done_in = 1'b0;
  logic [PTS_W-1:0]         pts = '0;
  logic                     rd_en;
  logic [PTS_W-1:0]         rd_addr;
  logic signed [DATA_W-1:0] rd_re = '0;
  logic signed [DATA_W-1:0] rd_im = '0;
  logic                     mag_start;
  logic [MAG_W-1:0]         mag;
  logic                     busy, frame_done, err;

  logic signed [DATA_W-1:0] ram_re [2**PTS_W];
  logic signed [DATA_W-1:0] ram_im [2**PTS_W];
  logic [MAG_W-1:0]         exp_q [$];

  int checks = 0;
  int passed = 0;

  fft_mag_streamer #(
    .PTS_W       (PTS_W),
    .DATA_W      (DATA_W),
    .MAG_W       (MAG_W),
    .DONE_TIMEOUT(TO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .go        (go),
    .pts       (pts),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_re     (rd_re),
    .rd_im     (rd_im),
    .mag_start (mag_start),
    .mag       (mag),
    .done_in   (done_in),
    .busy      (busy),
    .frame_done(frame_done),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Spectrum RAM: registered read, data one cycle after rd_en.
  always @(posedge clk) begin
    if (rd_en) begin
      rd_re <= ram_re[rd_addr];
      rd_im <= ram_im[rd_addr];
    end
  end

  function automatic logic [MAG_W-1:0] sq(input logic signed [DATA_W-1:0] re,
                                          input logic signed [DATA_W-1:0] im);
    longint r, i;
    r = longint'(re);
    i = longint'(im);
    return MAG_W'(r * r + i * i);
  endfunction

  task automatic test_reset;
    @(negedge clk);
    checks++; if ({rd_en, mag_start, busy, frame_done, err} !== 5'b0)
      $display("FAIL reset_flags got=%b exp=00000", {rd_en, mag_start, busy, frame_done, err});
    else passed++;
    checks++; if (rd_addr !== '0) $display("FAIL reset_addr got=%0h exp=0", rd_addr);
    else passed++;
    checks++; if (mag !== '0) $display("FAIL reset_mag got=%0h exp=0", mag);
    else passed++;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  // Full frame with a scoreboard; also pulses go and changes pts mid-frame.
  task automatic test_stream(input int n, input string tag);
    logic [MAG_W-1:0] e;
    exp_q.delete();
    for (int k = 0; k < n; k++) exp_q.push_back(sq(ram_re[k], ram_im[k]));
    go = 1'b1;
    pts = PTS_W'(n);
    @(posedge clk);
    @(negedge clk);
    go = 1'b0;
    for (int c = 1; c <= n + 10; c++) begin
      checks++; if (rd_en !== (c <= n))
        $display("FAIL %s_rd_en c=%0d got=%b exp=%b", tag, c, rd_en, (c <= n));
      else passed++;
      if (c <= n) begin
        checks++; if (rd_addr !== PTS_W'(c - 1))
          $display("FAIL %s_rd_addr c=%0d got=%0d exp=%0d", tag, c, rd_addr, c - 1);
        else passed++;
      end
      checks++; if (mag_start !== (c >= 4 && c <= n + 5))
        $display("FAIL %s_mag_start c=%0d got=%b exp=%b", tag, c, mag_start,
                 (c >= 4 && c <= n + 5));
      else passed++;
      e = '0;
      if (c >= 4 && c < 4 + n && exp_q.size() > 0) e = exp_q.pop_front();
      checks++; if (mag !== e)
        $display("FAIL %s_mag c=%0d got=%0h exp=%0h", tag, c, mag, e);
      else passed++;
      checks++; if (frame_done !== (c == n + 6))
        $display("FAIL %s_frame_done c=%0d got=%b exp=%b", tag, c, frame_done, (c == n + 6));
      else passed++;
      checks++; if (busy !== (c <= n + 6))
        $display("FAIL %s_busy c=%0d got=%b exp=%b", tag, c, busy, (c <= n + 6));
      else passed++;
      checks++; if (err !== 1'b0) $display("FAIL %s_err c=%0d got=%b exp=0", tag, c, err);
      else passed++;
      go = (c == 2);
      pts = (c == 2) ? PTS_W'(n + 3) : PTS_W'(n);
      done_in = (c == n + 5);
      @(negedge clk);
    end
    checks++; if (exp_q.size() != 0)
      $display("FAIL %s_leftover got=%0d exp=0", tag, exp_q.size());
    else passed++;
  endtask

  task automatic test_zero_pts;
    go = 1'b1;
    pts = '0;
    @(posedge clk);
    @(negedge clk);
    go = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      checks++; if (rd_en !== 1'b0) $display("FAIL zero_rd_en c=%0d got=%b exp=0", c, rd_en);
      else passed++;
      checks++; if (mag_start !== (c <= 5))
        $display("FAIL zero_mag_start c=%0d got=%b exp=%b", c, mag_start, (c <= 5));
      else passed++;
      checks++; if (mag !== '0) $display("FAIL zero_mag c=%0d got=%0h exp=0", c, mag);
      else passed++;
      checks++; if (frame_done !== (c == 6))
        $display("FAIL zero_frame_done c=%0d got=%b exp=%b", c, frame_done, (c == 6));
      else passed++;
      checks++; if (busy !== (c <= 6))
        $display("FAIL zero_busy c=%0d got=%b exp=%b", c, busy, (c <= 6));
      else passed++;
      done_in = (c == 5);
      @(negedge clk);
    end
  endtask

  task automatic test_timeout;
    logic [MAG_W-1:0] e;
    exp_q.delete();
    for (int k = 0; k < 8; k++) begin
      ram_re[k] = DATA_W'($urandom);
      ram_im[k] = DATA_W'($urandom);
      exp_q.push_back(sq(ram_re[k], ram_im[k]));
    end
    go = 1'b1;
    pts = PTS_W'(8);
    @(posedge clk);
    @(negedge clk);
    go = 1'b0;
    // WAIT_DONE occupies cycles 13..28, close at 29.
    for (int c = 1; c <= 32; c++) begin
      e = '0;
      if (c >= 4 && c < 12 && exp_q.size() > 0) e = exp_q.pop_front();
      checks++; if (mag !== e) $display("FAIL to_mag c=%0d got=%0h exp=%0h", c, mag, e);
      else passed++;
      checks++; if (mag_start !== (c >= 4 && c <= 28))
        $display("FAIL to_mag_start c=%0d got=%b exp=%b", c, mag_start, (c >= 4 && c <= 28));
      else passed++;
      checks++; if (frame_done !== (c == 29))
        $display("FAIL to_frame_done c=%0d got=%b exp=%b", c, frame_done, (c == 29));
      else passed++;
      checks++; if (busy !== (c <= 29))
        $display("FAIL to_busy c=%0d got=%b exp=%b", c, busy, (c <= 29));
      else passed++;
      checks++; if (err !== (c >= 29))
        $display("FAIL to_err c=%0d got=%b exp=%b", c, err, (c >= 29));
      else passed++;
      @(negedge clk);
    end
    go = 1'b1;
    pts = '0;
    @(posedge clk);
    @(negedge clk);
    go = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      checks++; if (err !== 1'b0) $display("FAIL to_err_clear c=%0d got=%b exp=0", c, err);
      else passed++;
      done_in = (c == 5);
      @(negedge clk);
    end
  endtask

  task automatic test_protocol_err;
    go = 1'b1;
    pts = PTS_W'(8);
    @(posedge clk);
    @(negedge clk);
    go = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      checks++; if (rd_en !== (c <= 3))
        $display("FAIL perr_rd_en c=%0d got=%b exp=%b", c, rd_en, (c <= 3));
      else passed++;
      if (c <= 3) begin
        checks++; if (rd_addr !== PTS_W'(c - 1))
          $display("FAIL perr_rd_addr c=%0d got=%0d exp=%0d", c, rd_addr, c - 1);
        else passed++;
      end
      checks++; if (mag_start !== 1'b0)
        $display("FAIL perr_mag_start c=%0d got=%b exp=0", c, mag_start);
      else passed++;
      checks++; if (mag !== '0) $display("FAIL perr_mag c=%0d got=%0h exp=0", c, mag);
      else passed++;
      checks++; if (frame_done !== (c == 4))
        $display("FAIL perr_frame_done c=%0d got=%b exp=%b", c, frame_done, (c == 4));
      else passed++;
      checks++; if (busy !== (c <= 4))
        $display("FAIL perr_busy c=%0d got=%b exp=%b", c, busy, (c <= 4));
      else passed++;
      checks++; if (err !== (c >= 4))
        $display("FAIL perr_err c=%0d got=%b exp=%b", c, err, (c >= 4));
      else passed++;
      done_in = (c >= 3 && c <= 5);
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid;
    for (int k = 0; k < 8; k++) begin
      ram_re[k] = DATA_W'($urandom_range(100, 1000));
      ram_im[k] = DATA_W'($urandom_range(100, 1000));
    end
    go = 1'b1;
    pts = PTS_W'(8);
    @(posedge clk);
    @(negedge clk);
    go = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (busy !== 1'b1 || rd_addr !== PTS_W'(4))
      $display("FAIL rmid_pre got=%b/%0d exp=1/4", busy, rd_addr);
    else passed++;
    reset = 1'b1;
    #1;
    checks++; if ({rd_en, mag_start, busy, frame_done, err} !== 5'b0)
      $display("FAIL rmid_flags got=%b exp=00000", {rd_en, mag_start, busy, frame_done, err});
    else passed++;
    checks++; if (rd_addr !== '0) $display("FAIL rmid_addr got=%0h exp=0", rd_addr);
    else passed++;
    checks++; if (mag !== '0) $display("FAIL rmid_mag got=%0h exp=0", mag);
    else passed++;
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      checks++; if ({rd_en, mag_start, busy, frame_done} !== 4'b0)
        $display("FAIL rmid_after c=%0d got=%b exp=0000", c,
                 {rd_en, mag_start, busy, frame_done});
      else passed++;
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset;
    ram_re[0] = 3;  ram_im[0] = 4;
    ram_re[1] = 0;  ram_im[1] = 0;
    ram_re[2] = -5; ram_im[2] = 12;
    ram_re[3] = 1;  ram_im[3] = -1;
    test_stream(4, "basic");
    ram_re[0] = -32768; ram_im[0] = -32768;
    test_stream(1, "maxneg");
    test_zero_pts;
    test_timeout;
    test_protocol_err;
    for (int k = 0; k < 16; k++) begin
      ram_re[k] = DATA_W'($urandom);
      ram_im[k] = DATA_W'($urandom);
    end
    test_stream(16, "rand");
    test_stream(16, "b2b");
    test_reset_mid;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
